wb_port_arbiter: RTL
====================

# wb_port_arbiter

Arbitrates the single register-file write port between the ALU result path and the variable-latency load-return path. It sits in front of the register file in place of a static memtoreg select, and makes the mem-vs-ALU choice per cycle with valid/ready handshakes. Every accepted write is committed through a registered output stage, so the register file sees one clean write per cycle. A starvation guard keeps a continuous stream of load returns from blocking ALU writebacks indefinitely.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- STARVE_LIMIT, 4, consecutive denied ALU cycles before ALU is promoted (1..2^CNT_W-1)
- CNT_W, 3, starvation counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load-return writeback request
- mem_ready  out  1  load request accepted this cycle
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load read data
- reg_we  out  1  register-file write enable (registered)
- reg_waddr  out  ADDR_W  write address (registered)
- reg_wdata  out  DATA_W  write data (registered)
- wb_src  out  1  source of the current write; 1 = mem, 0 = ALU (same polarity as memtoreg)

## Operation
- Transfer on a port occurs when valid && ready in the same cycle.
- At most one port gets ready per cycle. Ready is combinational from the valid inputs and the FSM state, and is forced to 0 while rst is high.
- FSM states:
  - PRI_MEM: reset state. mem wins whenever mem_valid. ALU gets ready only if !mem_valid.
  - PRI_ALU: ALU wins whenever alu_valid. mem gets ready only if !alu_valid.
- Starvation counter (starve_cnt, CNT_W bits, reset 0):
  - Increments, saturating, in PRI_MEM on each cycle with alu_valid && mem_valid.
  - Clears on any ALU transfer, or on any cycle with !alu_valid.
- Transitions:
  - PRI_MEM -> PRI_ALU when starve_cnt reaches STARVE_LIMIT (evaluated after the increment).
  - PRI_ALU -> PRI_MEM after one ALU transfer, or on any cycle in which alu_valid is low.
- Output stage:
  - On a transfer, the next edge loads reg_waddr/reg_wdata from the winner and sets wb_src to the winner's id.
  - reg_we = 1 unless the winner's rd == 0. A write to x0 is accepted (ready still asserted) but suppressed (reg_we = 0).
  - With no transfer, reg_we = 0 on the next edge; reg_waddr, reg_wdata and wb_src hold their previous values.
- No WAW reordering check. Upstream guarantees that simultaneous requests never target the same rd.

## Timing
- Latency: a transfer in cycle N produces reg_we in cycle N+1. Throughput is one write per cycle.
- The losing requester must hold valid/rd/data stable until it sees ready.
- Reset (asynchronous assert, synchronous-safe release):
  - reg_we = 0, reg_waddr = 0, reg_wdata = 0, wb_src = 0
  - state = PRI_MEM, starve_cnt = 0
  - alu_ready = 0, mem_ready = 0
- Reset mid-operation: a pending or in-flight write is dropped, with no write in the cycle following the rst assertion. Requesters re-present after reset.
- Both valid in PRI_MEM with STARVE_LIMIT = 4: mem is granted 4 cycles in a row, then ALU is granted on the 5th.
- With STARVE_LIMIT = 1: grants alternate mem/ALU under continuous contention.

## Configuration
- WB_STARVE_EN defined: the starvation counter and PRI_ALU state are compiled in, as described above.
- WB_STARVE_EN undefined:
  - Strict fixed priority, mem over ALU. No counter and no FSM state register.
  - STARVE_LIMIT and CNT_W are ignored.
  - ALU is ready only when !mem_valid.

## Structure
- Shared package wb_pkg holds:
  - DATA_W and ADDR_W defaults
  - the state enum (PRI_MEM, PRI_ALU)
  - constants WB_SRC_ALU = 0 and WB_SRC_MEM = 1
- One sub-module, wb_starve_fsm, contains the state register and the starvation counter and outputs alu_pri. It is instantiated only under WB_STARVE_EN.
- Grant logic and the output register stay in the top module.

## Test plan
- Reset: hold rst with both valids high -> both readys 0, reg_we = 0, all outputs 0. Release -> mem granted first.
- Single ALU request: alu_rd = 5, alu_data = 0x0000_00AA, no mem -> alu_ready = 1. Next cycle reg_we = 1, reg_waddr = 5, reg_wdata = 0xAA, wb_src = 0.
- Single mem request: mem_rd = 7, mem_data = 0xDEAD_BEEF -> next cycle reg_we = 1, reg_waddr = 7, wb_src = 1.
- Continuous contention, STARVE_LIMIT = 4:
  - Grant sequence is M,M,M,M,A, repeating.
  - With WB_STARVE_EN undefined, A is never granted while mem_valid stays high.
- x0 write: alu_rd = 0, alu_data = 0x1234 -> alu_ready = 1, next cycle reg_we = 0.
- Reset mid-stream: assert rst in the cycle after a mem transfer -> reg_we drops to 0 immediately. After release, state = PRI_MEM and starve_cnt = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef enum logic [0:0] {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } wb_state_e;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    // Returns 1 when the destination register is x0 (write is architecturally discarded).
    function automatic logic rd_is_x0(input logic [WB_ADDR_W-1:0] rd);
        return (rd == {WB_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/wb_starve_fsm.sv
// Priority FSM and starvation counter that promotes ALU writebacks after STARVE_LIMIT denials.
// Only compiled when WB_STARVE_EN is defined.
`ifdef WB_STARVE_EN
module wb_starve_fsm
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic mem_valid,
    input  logic alu_xfer,
    output logic alu_pri
);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRI_MEM;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the promotion test sees the already-incremented count.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (alu_xfer || !alu_valid) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == PRI_MEM) && mem_valid) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            PRI_MEM: begin
                if (cnt_d >= CNT_W'(STARVE_LIMIT)) state_d = PRI_ALU;
                else                               state_d = PRI_MEM;
            end
            PRI_ALU: begin
                if (alu_xfer || !alu_valid) state_d = PRI_MEM;
                else                        state_d = PRI_ALU;
            end
            default: state_d = PRI_MEM;
        endcase
    end

    // Priority output decode.
    always_comb begin
        alu_pri = 1'b0;
        case (state_q)
            PRI_ALU: alu_pri = 1'b1;
            PRI_MEM: alu_pri = 1'b0;
            default: alu_pri = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: ALU vs load-return, valid/ready, registered write stage.
// Define WB_STARVE_EN to enable the ALU starvation guard; otherwise mem has fixed priority.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              wb_src
);

    logic              alu_pri_s;
    logic              alu_ready_s, mem_ready_s;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              wb_src_q, wb_src_d;

`ifdef WB_STARVE_EN
    wb_starve_fsm #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_fsm (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_xfer  (alu_ready_s),
        .alu_pri   (alu_pri_s)
    );
`else
    logic [CNT_W-1:0] unused_cfg_s;
    assign unused_cfg_s = CNT_W'(STARVE_LIMIT);
    assign alu_pri_s    = 1'b0;
`endif

    // Grant: ready implies valid, so ready doubles as the transfer strobe.
    always_comb begin
        alu_ready_s = 1'b0;
        mem_ready_s = 1'b0;
        if (rst) begin
            alu_ready_s = 1'b0;
            mem_ready_s = 1'b0;
        end else if (alu_pri_s) begin
            alu_ready_s = alu_valid;
            mem_ready_s = mem_valid && !alu_valid;
        end else begin
            mem_ready_s = mem_valid;
            alu_ready_s = alu_valid && !mem_valid;
        end
    end

    assign alu_ready = alu_ready_s;
    assign mem_ready = mem_ready_s;

    // Write stage next values; x0 writes are accepted but never enabled.
    always_comb begin
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        wb_src_d    = wb_src_q;
        if (mem_ready_s) begin
            reg_we_d    = (mem_rd != {ADDR_W{1'b0}});
            reg_waddr_d = mem_rd;
            reg_wdata_d = mem_data;
            wb_src_d    = WB_SRC_MEM;
        end else if (alu_ready_s) begin
            reg_we_d    = (alu_rd != {ADDR_W{1'b0}});
            reg_waddr_d = alu_rd;
            reg_wdata_d = alu_data;
            wb_src_d    = WB_SRC_ALU;
        end else begin
            reg_we_d = 1'b0;
        end
    end

    // Registered write port toward the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we_q    <= 1'b0;
            reg_waddr_q <= {ADDR_W{1'b0}};
            reg_wdata_q <= {DATA_W{1'b0}};
            wb_src_q    <= WB_SRC_ALU;
        end else begin
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            wb_src_q    <= wb_src_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign wb_src    = wb_src_q;

endmodule
